// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, FSM state encodings and the bit-reverse helper
// for the fft_256 output reordering slice.
//   N        points per frame
//   LOG2N    address width within one bank
//   DW       signed width of each real/imag component
//   LAST_IDX index of the final sample in a frame
package fft_pkg;

  localparam int N     = 256;
  localparam int LOG2N = 8;
  localparam int DW    = 16;

  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_FILL = 2'd1,
    WR_DROP = 2'd2
  } wr_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RUN  = 1'b1
  } rd_state_t;

  // Mirror the LOG2N-bit index: bit i moves to bit LOG2N-1-i.
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = a[LOG2N-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// fft_pingpong_ram: two banks of N words, 2*DW bits wide, simple dual port.
// The MSB of each address selects the bank.
//   clk      system clock
//   wr_en    write strobe; wr_addr / wr_data written on the rising edge
//   rd_en    read strobe; rd_data updates one edge after rd_addr is
//            presented and holds its value while rd_en is low
module fft_pingpong_ram
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [LOG2N:0]    wr_addr,
  input  logic [2*DW-1:0]   wr_data,
  input  logic              rd_en,
  input  logic [LOG2N:0]    rd_addr,
  output logic [2*DW-1:0]   rd_data
);

  logic [2*DW-1:0] mem [0:2*N-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fft_out_reorder.sv
// fft_out_reorder: collects 256-point frames from the fft_256 core into a
// ping-pong buffer and replays each one as a sop/eop framed stream with
// valid/ready backpressure.
// Build option FFT_OUT_REORDER_BITREV_EN: when defined, samples are written
// at bitrev(index) so the replay is in natural frequency order; when
// undefined the block is a plain frame buffer preserving input order.
//   clk, rst             clock, synchronous active-high reset
//   valid_in, sop_in     input sample strobe / first sample of frame
//   din_re, din_im       input sample (signed)
//   ready_out            downstream accepts the current output
//   valid_out, sop_out, eop_out, dout_re, dout_im   output stream
//   ovf_err              sticky: frame dropped, no free bank
//   frm_err              sticky: sop_in arrived mid-frame
// Handshake: an output word transfers on an edge where valid_out and
// ready_out are both high; while valid_out is high and ready_out is low the
// output word and flags hold stable. The input side has no backpressure.
// The write FSM state (wr_state) and read FSM state (rd_state) are plain
// enum signals so checkers can bind to them.
module fft_out_reorder
  import fft_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic                 sop_in,
  input  logic signed [DW-1:0] din_re,
  input  logic signed [DW-1:0] din_im,
  input  logic                 ready_out,
  output logic                 valid_out,
  output logic                 sop_out,
  output logic                 eop_out,
  output logic signed [DW-1:0] dout_re,
  output logic signed [DW-1:0] dout_im,
  output logic                 ovf_err,
  output logic                 frm_err
);

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic [LOG2N-1:0] wcnt, rcnt, wr_idx, wr_lo;
  logic             wsel, rsel;
  logic [1:0]       full;
  logic             wr_en, wr_done, ovf_set, frm_set;
  logic             adv, rd_fire, rd_last;
  logic             s1_v, s1_sop, s1_eop;
  logic [2*DW-1:0]  rd_data;

  // ---------------- write FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) wr_state <= WR_IDLE;
    else     wr_state <= wr_next;
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE: if (valid_in && sop_in) wr_next = full[wsel] ? WR_DROP : WR_FILL;
      WR_FILL: if (valid_in && !sop_in && wcnt == LAST_IDX) wr_next = WR_IDLE;
      WR_DROP: if (valid_in && !sop_in && wcnt == LAST_IDX) wr_next = WR_IDLE;
      default: wr_next = WR_IDLE;
    endcase
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_done = 1'b0;
    ovf_set = 1'b0;
    frm_set = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        wr_en   = valid_in && sop_in && !full[wsel];
        ovf_set = valid_in && sop_in && full[wsel];
      end
      WR_FILL: begin
        // A sop here restarts the frame in place: the partial data is simply
        // overwritten, so no separate discard step is needed.
        wr_en   = valid_in;
        wr_done = valid_in && !sop_in && wcnt == LAST_IDX;
        frm_set = valid_in && sop_in;
      end
      default: ;
    endcase
  end

  assign wr_idx = sop_in ? '0 : wcnt;
`ifdef FFT_OUT_REORDER_BITREV_EN
  assign wr_lo = bitrev(wr_idx);
`else
  assign wr_lo = wr_idx;
`endif

  // ---------------- read FSM ----------------
  // Two-stage read pipeline (RAM register, then output register) that
  // advances as a unit whenever the output register is empty or draining.
  assign adv = !valid_out || ready_out;

  always_ff @(posedge clk) begin
    if (rst) rd_state <= RD_IDLE;
    else     rd_state <= rd_next;
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (rd_fire) rd_next = RD_RUN;
      RD_RUN:  if (rd_last) rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  // Word 0 is issued straight from RD_IDLE, so a full bank waiting behind the
  // one just finished is picked up on the very next cycle with no bubble.
  always_comb begin
    rd_fire = adv && (rd_state == RD_RUN || full[rsel]);
    rd_last = rd_fire && rcnt == LAST_IDX;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt      <= '0;
      wsel      <= 1'b0;
      rcnt      <= '0;
      rsel      <= 1'b0;
      full      <= 2'b00;
      ovf_err   <= 1'b0;
      frm_err   <= 1'b0;
      s1_v      <= 1'b0;
      s1_sop    <= 1'b0;
      s1_eop    <= 1'b0;
      valid_out <= 1'b0;
      sop_out   <= 1'b0;
      eop_out   <= 1'b0;
      dout_re   <= '0;
      dout_im   <= '0;
    end else begin
      if (valid_in && (wr_state != WR_IDLE || sop_in)) begin
        wcnt <= sop_in ? LOG2N'(1) : wcnt + 1'b1;
      end
      if (wr_done) begin
        full[wsel] <= 1'b1;
        wsel       <= ~wsel;
      end
      if (ovf_set) ovf_err <= 1'b1;
      if (frm_set) frm_err <= 1'b1;

      if (rd_fire) rcnt <= rcnt + 1'b1;
      // The bank is released once its last word has been captured out of
      // the RAM; the pipeline registers carry the remaining data.
      if (rd_last) begin
        full[rsel] <= 1'b0;
        rsel       <= ~rsel;
      end

      if (adv) begin
        s1_v      <= rd_fire;
        s1_sop    <= rd_fire && rcnt == '0;
        s1_eop    <= rd_last;
        valid_out <= s1_v;
        sop_out   <= s1_v && s1_sop;
        eop_out   <= s1_v && s1_eop;
        if (s1_v) begin
          dout_re <= rd_data[2*DW-1:DW];
          dout_im <= rd_data[DW-1:0];
        end
      end
    end
  end

  fft_pingpong_ram u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr ({wsel, wr_lo}),
    .wr_data ({din_re, din_im}),
    .rd_en   (rd_fire),
    .rd_addr ({rsel, rcnt}),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_fft_out_reorder.sv
// tb_fft_out_reorder: scoreboard bench for fft_out_reorder. Expected output
// words are pushed when an accepted frame has been driven and popped as the
// DUT transfers words downstream.
module tb_fft_out_reorder;

  localparam int N  = 256;
  localparam int DW = 16;
`ifdef FFT_OUT_REORDER_BITREV_EN
  localparam bit BITREV_EN = 1'b1;
`else
  localparam bit BITREV_EN = 1'b0;
`endif

  logic                 clk, rst;
  logic                 valid_in, sop_in, ready_out;
  logic signed [DW-1:0] din_re, din_im;
  logic                 valid_out, sop_out, eop_out, ovf_err, frm_err;
  logic signed [DW-1:0] dout_re, dout_im;

  fft_out_reorder dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .sop_in    (sop_in),
    .din_re    (din_re),
    .din_im    (din_im),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .sop_out   (sop_out),
    .eop_out   (eop_out),
    .dout_re   (dout_re),
    .dout_im   (dout_im),
    .ovf_err   (ovf_err),
    .frm_err   (frm_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  logic [2*DW+1:0] exp_q[$];
  logic [2*DW+1:0] cur_word, hold_word, exp_word;
  bit              hold_pend = 1'b0;
  int              n_checks = 0;
  int              n_pass = 0;
  int              n_xfer = 0;
  int              last_xfer_cyc = -1;
  int              bubbles = 0;
  int              rmode = 0;   // 0: ready high, 1: toggle, 2: ready low

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic int tb_bitrev(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 8; i++) if (v[i]) r |= (1 << (7 - i));
    return r;
  endfunction

  // ---------------- drivers ----------------
  initial begin
    ready_out = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       ready_out = 1'b1;
        1:       ready_out = ~ready_out;
        default: ready_out = 1'b0;
      endcase
    end
  end

  task automatic drive_frame(input int base, input int nsamp, input bit push);
    int src;
    for (int j = 0; j < nsamp; j++) begin
      @(posedge clk);
      #1;
      valid_in = 1'b1;
      sop_in   = (j == 0);
      din_re   = 16'(base + j);
      din_im   = 16'(-(base + j));
    end
    if (push) begin
      for (int b = 0; b < N; b++) begin
        src = BITREV_EN ? tb_bitrev(b) : b;
        exp_q.push_back({(b == 0), (b == N - 1), 16'(base + src), 16'(-(base + src))});
      end
    end
  endtask

  task automatic drive_idle();
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    sop_in   = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
    wait_cycles(4);
    check_val("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_valid_out"}, valid_out, 0);
    check_val({tag, "_sop_out"}, sop_out, 0);
    check_val({tag, "_eop_out"}, eop_out, 0);
    check_val({tag, "_dout_re"}, dout_re, 0);
    check_val({tag, "_dout_im"}, dout_im, 0);
    check_val({tag, "_ovf_err"}, ovf_err, 0);
    check_val({tag, "_frm_err"}, frm_err, 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      cur_word = {sop_out, eop_out, dout_re, dout_im};
      if (hold_pend && valid_out) check_val("stall_hold", cur_word, hold_word);
      hold_pend = valid_out && !ready_out;
      hold_word = cur_word;
      if (valid_out && ready_out) begin
        n_xfer++;
        if (last_xfer_cyc != -1 && cyc != last_xfer_cyc + 1) bubbles++;
        last_xfer_cyc = cyc;
        if (exp_q.size() == 0) begin
          check_val("unexpected_output", 1, 0);
        end else begin
          exp_word = exp_q.pop_front();
          check_val("out_word", cur_word, exp_word);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  int mark;

  initial begin
    rst = 1'b1; valid_in = 1'b0; sop_in = 1'b0; din_re = '0; din_im = '0;
    wait_cycles(4);
    check_idle_outputs("reset");
    rst = 1'b0;

    // Single frame, ready high: ordering, framing and 2-cycle latency.
    rmode = 0;
    mark = n_xfer;
    drive_frame(0, N, 1'b1);
    drive_idle();                     // now just after the edge that wrote the last sample
    check_val("lat_k0_valid", valid_out, 0);
    wait_cycles(1);
    check_val("lat_k1_valid", valid_out, 0);
    wait_cycles(1);
    check_val("lat_k2_valid", valid_out, 1);
    check_val("lat_k2_sop", sop_out, 1);
    check_val("lat_k2_bin0_re", dout_re, 0);
    wait_drain(600);
    check_val("single_count", n_xfer - mark, N);

    // Two back-to-back frames: contiguous 512-word stream.
    mark = n_xfer;
    bubbles = 0;
    last_xfer_cyc = -1;
    drive_frame(256, N, 1'b1);
    drive_frame(512, N, 1'b1);
    drive_idle();
    wait_drain(1000);
    check_val("b2b_count", n_xfer - mark, 2 * N);
    check_val("b2b_bubbles", bubbles, 0);

    // ready toggling every cycle: stall hold and no loss.
    rmode = 1;
    mark = n_xfer;
    drive_frame(768, N, 1'b1);
    drive_idle();
    wait_drain(1500);
    check_val("toggle_count", n_xfer - mark, N);

    // ready low over three frames: two buffered, third dropped.
    rmode = 2;
    wait_cycles(2);
    mark = n_xfer;
    drive_frame(1024, N, 1'b1);
    drive_frame(1280, N, 1'b1);
    drive_frame(1536, N, 1'b0);
    drive_idle();
    wait_cycles(10);
    check_val("ovf_flag", ovf_err, 1);
    check_val("ovf_no_frm", frm_err, 0);
    check_val("ovf_stalled_count", n_xfer - mark, 0);
    check_val("ovf_stalled_valid", valid_out, 1);
    rmode = 0;
    wait_drain(1500);
    check_val("ovf_release_count", n_xfer - mark, 2 * N);
    wait_cycles(20);
    check_val("ovf_after_valid", valid_out, 0);

    // sop at sample 100: partial discarded, following frame emitted.
    mark = n_xfer;
    drive_frame(1792, 100, 1'b0);
    drive_frame(2048, N, 1'b1);
    drive_idle();
    wait_drain(1000);
    check_val("frm_flag", frm_err, 1);
    check_val("frm_count", n_xfer - mark, N);

    // Reset mid-frame while an output is held: everything cleared, no output.
    rmode = 2;
    wait_cycles(2);
    drive_frame(2304, N, 1'b0);
    drive_frame(2560, 50, 1'b0);
    drive_idle();
    wait_cycles(3);
    check_val("pre_rst_valid", valid_out, 1);
    rst = 1'b1;
    wait_cycles(1);
    check_idle_outputs("midrst");
    rst = 1'b0;
    rmode = 0;
    mark = n_xfer;
    wait_cycles(300);
    check_val("post_rst_count", n_xfer - mark, 0);
    check_val("post_rst_valid", valid_out, 0);
    check_val("post_rst_queue", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fft_out_reorder.md
Name: fft_out_reorder

Overview:
- Receiving end of the fft_256 output stream (valid/sop + 16-bit complex samples).
- Collects each 256-point frame into a ping-pong buffer and re-emits it in natural frequency order.
- Core output arrives in bit-reversed order.
- Emits a framed stream (sop/eop) with downstream backpressure to the next block (magnitude/file sink).

Parameters:
- N, 256, points per frame (power of 2)
- LOG2N, 8, address width, log2(N)
- DW, 16, signed width of each real/imag component

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- valid_in  in  1  input sample valid (from fft_256 valid_out)
- sop_in  in  1  first sample of frame (from fft_256 sop_out)
- din_re  in  DW  input real, signed
- din_im  in  DW  input imag, signed
- ready_out  in  1  downstream accepts sample this cycle
- valid_out  out  1  output sample valid
- sop_out  out  1  first natural-order sample (bin 0)
- eop_out  out  1  last sample (bin N-1)
- dout_re  out  DW  output real, signed
- dout_im  out  DW  output imag, signed
- ovf_err  out  1  sticky: frame dropped, no free bank
- frm_err  out  1  sticky: sop_in arrived mid-frame

Behaviour:
- Reset: all outputs 0; both banks free; write FSM WR_IDLE; read FSM RD_IDLE; counters 0.
- No input backpressure; a sample is accepted on every cycle with valid_in=1.
- Write FSM states: WR_IDLE, WR_FILL, WR_DROP.
  - WR_IDLE: valid_in without sop_in is ignored. valid_in&sop_in with a free bank: write sample 0, wcnt=1, go WR_FILL. With no free bank: set ovf_err, go WR_DROP.
  - WR_FILL: each valid_in writes bank[wsel][bitrev(wcnt)], wcnt++. A cycle with valid_in=0 holds state. When the sample at wcnt=N-1 is written, mark bank full, toggle wsel, go WR_IDLE.
  - sop_in in WR_FILL with wcnt!=0: set frm_err, discard the partial frame, restart at wcnt=0 with this sample as sample 0.
  - WR_DROP: discard samples until N are counted, then WR_IDLE. sop_in here restarts the drop count.
- Read FSM states: RD_IDLE, RD_RUN.
  - RD_IDLE: leave when bank[rsel] is full; go RD_RUN, rcnt=0.
  - RD_RUN reads bank[rsel][rcnt] through 1-cycle synchronous RAM into output registers.
  - Standard valid/ready: an output holds stable while valid_out&!ready_out. Transfer occurs on valid_out&ready_out.
  - sop_out=1 with rcnt 0 data; eop_out=1 with rcnt N-1 data.
  - After the N-1 transfer: free bank[rsel], toggle rsel, return to RD_IDLE, or chain directly into the next full bank with no bubble.
- Latency: last input sample written at edge k -> valid_out=1 with bin 0 after edge k+2 (ready_out=1).
- Throughput: 1 sample/cycle sustained with ready_out=1; the two banks never both fill.
- Simultaneous events: a write completing and a read freeing a bank on the same edge both take effect; the freed bank is available to sop_in on the next edge.
- Error flags clear only on rst.
- rst mid-frame: partial frames discarded, both banks freed, output stream aborted (valid_out=0 next cycle).

Optional Feature:
- Macro: FFT_OUT_REORDER_BITREV_EN.
- Defined: write address = bitrev(wcnt); output is in natural order.
- Undefined: write address = wcnt; the block is a pure frame buffer with sop/eop framing and backpressure, preserving input order.

Decomposition:
- Shared package fft_pkg: N, LOG2N, DW, FSM state encodings, bitrev function (parametrized on LOG2N).
- One sub-module: fft_pingpong_ram, a 2xN entry, 2*DW wide simple dual-port RAM with 1-cycle registered read.

Test Plan:
- Frame with sample j: re=j, im=-j, ready_out=1 -> out bin1 re=128, bin2 re=64, bin255 re=255. sop_out on bin0, eop_out on bin255. First valid_out 2 cycles after the last input.
- Macro undefined, same frame -> output re=0..255 in order.
- Two back-to-back frames, ready_out=1 -> 512 contiguous outputs, no bubble, sop_out at positions 0 and 256.
- ready_out toggling 1/0 every cycle -> data held stable while stalled, no loss, eop_out on the 256th transfer.
- ready_out=0 throughout three frames -> frames 1-2 buffered, frame 3 dropped, ovf_err=1. Release ready_out -> exactly 512 outputs.
- sop_in at sample 100, then a full frame -> frm_err=1, only the second frame emitted. rst at sample 50 -> all outputs 0, no output afterwards.
